// File: rtl/imem_pkg.sv
// Shared widths, word-address slice positions and response owner encoding
// for the instruction-memory arbiter.
package imem_pkg;

  localparam int IMEM_INST_LEN  = 32;
  localparam int IMEM_PC_LEN    = 32;
  localparam int IMEM_MADDR_LEN = 18;
  localparam int IMEM_STALL_LEN = 16;

  // Byte address bits WADDR_MSB:WADDR_LSB form the memory word address.
  localparam int WADDR_LSB = 2;
  localparam int WADDR_MSB = WADDR_LSB + IMEM_MADDR_LEN - 1;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_LOAD  = 2'b10
  } owner_t;

endpackage

// File: rtl/imem_sat_counter.sv
// Saturating up-counter with enable and synchronous reset; holds at all-ones.
// Count visible the cycle after an enabled edge; no backpressure.
module imem_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for the single-port imem: combinational grant, 1-cycle response; losers hold req.
// IMEM_ARB_RR_EN selects round-robin on contested cycles instead of fixed loader > fetch priority.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int INST_WIDTH_LENGTH = IMEM_INST_LEN,
  parameter int PC_WIDTH_LENGTH   = IMEM_PC_LEN,
  parameter int MEM_ADDR_LENGTH   = IMEM_MADDR_LEN,
  parameter int STALL_CNT_LENGTH  = IMEM_STALL_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         f_req,
  input  logic [PC_WIDTH_LENGTH-1:0]   f_addr,
  output logic                         f_gnt,
  output logic                         f_rvalid,
  output logic [INST_WIDTH_LENGTH-1:0] f_rdata,
  output logic                         f_err,
  input  logic                         l_req,
  input  logic                         l_we,
  input  logic [PC_WIDTH_LENGTH-1:0]   l_addr,
  input  logic [INST_WIDTH_LENGTH-1:0] l_wdata,
  input  logic                         l_lock,
  output logic                         l_gnt,
  output logic                         l_rvalid,
  output logic [INST_WIDTH_LENGTH-1:0] l_rdata,
  output logic                         l_err,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [MEM_ADDR_LENGTH-1:0]   mem_addr,
  output logic [INST_WIDTH_LENGTH-1:0] mem_wdata,
  input  logic [INST_WIDTH_LENGTH-1:0] mem_rdata,
  output logic [STALL_CNT_LENGTH-1:0]  stall_cnt
);

  logic                       l_win;
  logic                       any_gnt;
  logic                       misaligned;
  logic [PC_WIDTH_LENGTH-1:0] sel_addr;
  owner_t                     owner_q;
  logic                       err_q;
  logic                       data_q;
  logic                       unused_addr_hi;

`ifdef IMEM_ARB_RR_EN
  // last_l=1: loader won the previous contested cycle. Reset value lets the loader win first.
  logic last_l;

  assign l_win = l_req & (l_lock | ~f_req | ~last_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_l <= 1'b0;
    end else if (f_req && l_req && !l_lock) begin
      last_l <= l_win;
    end
  end
`else
  assign l_win = l_req;
`endif

  assign l_gnt   = ~rst & l_win;
  assign f_gnt   = ~rst & f_req & ~l_lock & ~l_win;
  assign any_gnt = l_gnt | f_gnt;

  assign sel_addr   = l_gnt ? l_addr : f_addr;
  assign misaligned = |sel_addr[WADDR_LSB-1:0];

  assign mem_en    = any_gnt & ~misaligned;
  assign mem_we    = l_gnt & l_we & ~misaligned;
  assign mem_addr  = sel_addr[WADDR_LSB +: MEM_ADDR_LENGTH];
  assign mem_wdata = mem_we ? l_wdata : '0;

  // Bits above the word-address slice are ignored: accesses wrap modulo the memory size.
  assign unused_addr_hi = ^sel_addr[PC_WIDTH_LENGTH-1:WADDR_LSB+MEM_ADDR_LENGTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      owner_q <= l_gnt ? OWN_LOAD : (f_gnt ? OWN_FETCH : OWN_NONE);
      err_q   <= any_gnt & misaligned;
      data_q  <= any_gnt & ~misaligned & ~(l_gnt & l_we);
    end
  end

  // Gating with rst drops a response that was in flight when reset arrived.
  assign f_rvalid = ~rst & (owner_q == OWN_FETCH);
  assign l_rvalid = ~rst & (owner_q == OWN_LOAD);
  assign f_err    = f_rvalid & err_q;
  assign l_err    = l_rvalid & err_q;
  assign f_rdata  = (f_rvalid & data_q) ? mem_rdata : '0;
  assign l_rdata  = (l_rvalid & data_q) ? mem_rdata : '0;

  imem_sat_counter #(
    .WIDTH (STALL_CNT_LENGTH)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (f_req & ~f_gnt),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small synchronous memory model behind the port.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        mem_en, mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] tmem [0:255];
  logic        tmem_init = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!tmem_init) begin
      for (int i = 0; i < 256; i++) tmem[i] <= 32'h0;
      tmem[2]   <= 32'h0010_0093;
      tmem_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) tmem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[7:0]];
    end
  end

  imem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .f_err     (f_err),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_lock    (l_lock),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .l_err     (l_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_cnt (stall_cnt)
  );

  task automatic test_reset();
    rst = 1'b1; f_req = 1'b1; f_addr = 32'h8;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0; l_lock = 1'b0;
    @(negedge clk);
    checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL reset_f_gnt: got %b want 0", f_gnt); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
    checks++; if ({f_rvalid, l_rvalid, f_err, l_err} !== 4'b0) begin errors++; $display("FAIL reset_resp: got %b want 0000", {f_rvalid, l_rvalid, f_err, l_err}); end
    @(posedge clk); #1;
    rst = 1'b0; f_req = 1'b0;
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h0000_0008;
    @(negedge clk);
    checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt: got f=%b l=%b want f=1 l=0", f_gnt, l_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 18'd2) begin errors++; $display("FAIL fetch_mem: got en=%b we=%b addr=%h want 1 0 2", mem_en, mem_we, mem_addr); end
    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    checks++; if (f_rvalid !== 1'b1 || f_err !== 1'b0 || l_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid: got rv=%b err=%b lrv=%b want 1 0 0", f_rvalid, f_err, l_rvalid); end
    checks++; if (f_rdata !== 32'h0010_0093) begin errors++; $display("FAIL fetch_rdata: got %h want 00100093", f_rdata); end
  endtask

  task automatic test_load_write();
    @(posedge clk); #1;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h40; l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (l_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 18'h10 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_wr_port: got gnt=%b we=%b addr=%h wd=%h want 1 1 10 deadbeef", l_gnt, mem_we, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    l_req = 1'b0; l_we = 1'b0;
    f_req = 1'b1; f_addr = 32'h40;
    @(negedge clk);
    checks++; if (l_rvalid !== 1'b1 || l_rdata !== 32'h0 || l_err !== 1'b0) begin errors++; $display("FAIL load_wr_ack: got rv=%b rd=%h err=%b want 1 0 0", l_rvalid, l_rdata, l_err); end
    checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL readback_gnt: got %b want 1", f_gnt); end
    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL readback_data: got rv=%b rd=%h want 1 deadbeef", f_rvalid, f_rdata); end
  endtask

  task automatic test_contention();
    logic [2:0]  exp_l;
    logic [15:0] exp_stall;
`ifdef IMEM_ARB_RR_EN
    exp_l = 3'b101; exp_stall = 16'd2;
`else
    exp_l = 3'b111; exp_stall = 16'd3;
`endif
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h8;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (l_gnt !== exp_l[2-c] || f_gnt !== ~exp_l[2-c]) begin errors++; $display("FAIL contend_gnt%0d: got l=%b f=%b want l=%b f=%b", c, l_gnt, f_gnt, exp_l[2-c], ~exp_l[2-c]); end
      @(posedge clk); #1;
    end
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL contend_stall: got %0d want %0d", stall_cnt, exp_stall); end
    checks++; if (l_rvalid !== 1'b1 || l_rdata !== 32'h0010_0093 || f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin errors++; $display("FAIL contend_resp: got lrv=%b lrd=%h frv=%b frd=%h", l_rvalid, l_rdata, f_rvalid, f_rdata); end
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h42; l_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (l_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_load_port: got gnt=%b en=%b we=%b want 1 0 0", l_gnt, mem_en, mem_we); end
    @(posedge clk); #1;
    l_req = 1'b0; l_we = 1'b0;
    f_req = 1'b1; f_addr = 32'h0000_0006;
    @(negedge clk);
    checks++; if (l_rvalid !== 1'b1 || l_err !== 1'b1 || l_rdata !== 32'h0) begin errors++; $display("FAIL mis_load_resp: got rv=%b err=%b rd=%h want 1 1 0", l_rvalid, l_err, l_rdata); end
    checks++; if (f_gnt !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL mis_fetch_port: got gnt=%b en=%b want 1 0", f_gnt, mem_en); end
    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    checks++; if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== 32'h0 || l_rvalid !== 1'b0) begin errors++; $display("FAIL mis_fetch_resp: got rv=%b err=%b rd=%h lrv=%b want 1 1 0 0", f_rvalid, f_err, f_rdata, l_rvalid); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h0010_0040;
    @(negedge clk);
    checks++; if (f_gnt !== 1'b1 || mem_addr !== 18'h10) begin errors++; $display("FAIL b2b_wrap_addr: got gnt=%b addr=%h want 1 10", f_gnt, mem_addr); end
    @(posedge clk); #1;
    f_addr = 32'h8;
    @(negedge clk);
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEAD_BEEF || f_gnt !== 1'b1 || mem_addr !== 18'd2) begin errors++; $display("FAIL b2b_second: got rv=%b rd=%h gnt=%b addr=%h", f_rvalid, f_rdata, f_gnt, mem_addr); end
    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h0010_0093) begin errors++; $display("FAIL b2b_third: got rv=%b rd=%h want 1 00100093", f_rvalid, f_rdata); end
  endtask

  task automatic test_lock_saturation();
    int gnt_seen;
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h8;
    @(negedge clk);
    checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL lock_pre_gnt: got %b want 1", f_gnt); end
    @(posedge clk); #1;
    l_lock = 1'b1;
    @(negedge clk);
    checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b0) begin errors++; $display("FAIL lock_block: got f=%b l=%b want 0 0", f_gnt, l_gnt); end
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h0010_0093) begin errors++; $display("FAIL lock_inflight: got rv=%b rd=%h want 1 00100093", f_rvalid, f_rdata); end
    @(posedge clk); #1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h40;
    @(negedge clk);
    checks++; if (l_gnt !== 1'b1 || f_gnt !== 1'b0) begin errors++; $display("FAIL lock_loader: got l=%b f=%b want 1 0", l_gnt, f_gnt); end
    @(posedge clk); #1;
    l_req = 1'b0;
    gnt_seen = 0;
    repeat (70000) begin
      @(negedge clk);
      if (f_gnt) gnt_seen++;
    end
    checks++; if (gnt_seen !== 0) begin errors++; $display("FAIL lock_f_gnt: got %0d grants want 0", gnt_seen); end
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h want ffff", stall_cnt); end
    @(posedge clk); #1;
    l_lock = 1'b0; f_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h8;
    @(negedge clk);
    checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b want 1", f_gnt); end
    @(posedge clk); #1;
    rst = 1'b1; f_req = 1'b0;
    @(negedge clk);
    checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_drop: got rv=%b rd=%h want 0 0", f_rvalid, f_rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({f_rvalid, l_rvalid, f_err, l_err, mem_en, mem_we, f_gnt, l_gnt} !== 8'b0) begin errors++; $display("FAIL rstmid_outs: got %b want 00000000", {f_rvalid, l_rvalid, f_err, l_err, mem_en, mem_we, f_gnt, l_gnt}); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_stall: got %h want 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_write();
    test_contention();
    test_misaligned();
    test_back_to_back();
    test_lock_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port synchronous instruction memory between two requesters: the pipeline fetch stage (read-only) and the program loader/debug port (read/write).
- Arbitrates one access per cycle and steers the memory port.
- Returns read data and a 1-cycle-latency response to the winner.
- Flags misaligned accesses without touching memory.
- Keeps a saturating fetch-stall counter for performance debug.

Parameters:
- INST_WIDTH_LENGTH, 32, instruction/data word width
- PC_WIDTH_LENGTH, 32, requester address width (byte address)
- MEM_ADDR_LENGTH, 18, memory word-address width (1<<18 words)
- STALL_CNT_LENGTH, 16, width of the stall counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held until granted
- f_addr  in  PC_WIDTH_LENGTH  fetch byte address (PC)
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch response valid
- f_rdata  out  INST_WIDTH_LENGTH  fetched instruction
- f_err  out  1  misaligned-fetch flag, qualified by f_rvalid
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  PC_WIDTH_LENGTH  loader byte address
- l_wdata  in  INST_WIDTH_LENGTH  loader write data
- l_lock  in  1  loader owns memory exclusively; fetch is never granted
- l_gnt  out  1  loader granted this cycle (combinational)
- l_rvalid  out  1  loader response/ack valid
- l_rdata  out  INST_WIDTH_LENGTH  loader read data
- l_err  out  1  misaligned-loader flag, qualified by l_rvalid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  MEM_ADDR_LENGTH  word address = winner addr[19:2]
- mem_wdata  out  INST_WIDTH_LENGTH  write data
- mem_rdata  in  INST_WIDTH_LENGTH  memory read data, valid the cycle after mem_en
- stall_cnt  out  STALL_CNT_LENGTH  cycles with f_req=1 and f_gnt=0, saturating

Behaviour:
- Reset (rst=1 at posedge): f_rvalid, l_rvalid, f_err, l_err, stall_cnt and last-winner state all go to 0. An in-flight response is dropped; no rvalid follows reset. While rst=1, f_gnt, l_gnt, mem_en and mem_we are 0.
- Grant rules, same cycle, combinational from requests and state; at most one grant per cycle:
  - l_lock=1: only the loader can be granted.
  - Otherwise, default fixed priority loader > fetch.
- Misalignment: addr[1:0] != 0 is granted normally but mem_en=0 and mem_we=0. Next cycle: rvalid=1, err=1, rdata=0. Writes are discarded.
- Aligned grant: mem_en=1, mem_addr=addr[19:2], mem_we=l_we for the loader and 0 for fetch. Address bits above bit 19 are ignored (wrap modulo 1 MiB).
- Response: a registered owner tag and err bit select the responder.
  - Exactly one cycle after the grant, the owner's rvalid=1 for one cycle.
  - rdata = mem_rdata for reads; 0 for writes and errors.
  - Non-owner rdata=0.
- Back-to-back: a new grant is allowed every cycle. The response to grant N coincides with grant N+1.
- Requester rule: after gnt, the requester may change its addr or drop req. Dropping req before gnt is legal and cancels the request.
- stall_cnt: increments when f_req=1 and f_gnt=0. Holds at all-ones; never wraps.
- l_lock asserted mid-stream: takes effect the same cycle. A fetch response already in flight still completes.

Optional Feature:
- IMEM_ARB_RR_EN defined: when both request, l_lock=0 and the previous grant of the simultaneous-request pair went to X, the other requester wins (round-robin). The last-winner flop updates only on contested cycles; its reset value favours the loader.
- Not defined: fixed priority loader > fetch, and the last-winner flop is absent.

Decomposition:
- Package imem_pkg:
  - width constants (INST/PC/MEM_ADDR lengths)
  - owner encoding: OWN_NONE=2'b00, OWN_FETCH=2'b01, OWN_LOAD=2'b10
  - word-address slice constants (bits 19:2)
- Sub-module: imem_sat_counter, a parameterised saturating counter with enable and synchronous reset, used for stall_cnt.
- Arbitration and response pipeline stay in the top level.

Test Plan:
- Fetch only: f_req=1, f_addr=0x0000_0008, memory word 2 = 0x0010_0093 -> same cycle f_gnt=1, mem_addr=2; next cycle f_rvalid=1, f_rdata=0x0010_0093, f_err=0.
- Loader write then fetch read-back: l_we=1, l_addr=0x40, l_wdata=0xDEAD_BEEF -> mem_we=1, mem_addr=0x10; l_rvalid next cycle. A following fetch of 0x40 returns 0xDEAD_BEEF.
- Contention, fixed priority: f_req and l_req both held for 3 cycles -> l_gnt each cycle, f_gnt=0, stall_cnt=3. With IMEM_ARB_RR_EN: grants alternate L, F, L.
- Misaligned fetch: f_addr=0x0000_0006 -> f_gnt=1, mem_en=0; next cycle f_rvalid=1, f_err=1, f_rdata=0.
- Lock and saturation: l_lock=1 with f_req=1 held for 70000 cycles and STALL_CNT_LENGTH=16 -> f_gnt never asserted, stall_cnt stops at 0xFFFF.
- Reset mid-operation: rst=1 in the cycle after a fetch grant -> no f_rvalid. Next cycle all outputs are 0 and stall_cnt=0.
